// File: rtl/phase_gen_par_pkg.sv
// Shared definitions for the parallel NCO phase generator: FSM states and default geometry.
package phase_gen_par_pkg;

  localparam int unsigned DEF_LANES   = 4;
  localparam int unsigned DEF_PHASE_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/phase_gen_par_skid_buf.sv
// Two-entry valid/ready skid buffer with registered output; zero-bubble at full rate.
// Accepts a new entry while full only if the head retires in the same cycle.
module phase_skid_buf #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = head_q;
  assign in_rdy  = (cnt_q != 2'd2) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            head_q <= in_dat;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_q <= in_dat;
          end else if (push) begin
            tail_q <= in_dat;
            cnt_q  <= 2'd2;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end
        end
        2'd2: begin
          // a push while full is only possible alongside a pop
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= in_dat;
            end else begin
              cnt_q <= 2'd1;
            end
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/phase_gen_par.sv
// Multi-lane NCO phase generator: LANES consecutive samples per beat, 2 cycles en_i->valid_o.
// Stalls the accumulator under ready_i backpressure via a 2-entry skid; config applies beat-aligned.
module phase_gen_par
  import phase_gen_par_pkg::*;
#(
  parameter int unsigned LANES   = DEF_LANES,
  parameter int unsigned PHASE_W = DEF_PHASE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [PHASE_W-1:0]       cfg_pinc_i,
  input  logic [PHASE_W-1:0]       cfg_poff_i,
  input  logic                     cfg_sync_i,
  output logic                     cfg_applied_o,
  output logic [LANES*PHASE_W-1:0] phase_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   acc_q, acc_d;
  logic [PHASE_W-1:0]   pinc_q, poff_q;
  logic [PHASE_W-1:0]   sh_pinc_q, sh_poff_q;
  logic                 sh_sync_q;
  logic                 pend_q;
  logic                 buf_in_rdy;
  logic                 gen;
  logic                 accept;
  logic                 apply;
  logic [PHASE_W-1:0]   beat_step;
  logic [LANES*PHASE_W-1:0] lane_dat;

  assign beat_step = pinc_q * PHASE_W'(LANES);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_dat[k*PHASE_W +: PHASE_W] = acc_q + poff_q + pinc_q * PHASE_W'(k);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gen     = 1'b0;
    accept  = 1'b0;
    apply   = 1'b0;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: if (en_i)  state_d = ST_RUN;
      ST_RUN:  if (!en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    gen    = (state_q == ST_RUN) && buf_in_rdy;
    accept = cfg_valid_i && !pend_q;
    // pend_q gates apply, so a config is never applied in its own accept cycle
    apply  = pend_q && (gen || (state_q == ST_IDLE));
    if (gen) begin
      acc_d = acc_q + beat_step;
    end
    if (apply && sh_sync_q) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      pinc_q    <= '0;
      poff_q    <= '0;
      sh_pinc_q <= '0;
      sh_poff_q <= '0;
      sh_sync_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (accept) begin
        sh_pinc_q <= cfg_pinc_i;
        sh_poff_q <= cfg_poff_i;
        sh_sync_q <= cfg_sync_i;
        pend_q    <= 1'b1;
      end else if (apply) begin
        pinc_q <= sh_pinc_q;
        poff_q <= sh_poff_q;
        pend_q <= 1'b0;
      end
    end
  end

  assign cfg_ready_o   = !pend_q;
  assign cfg_applied_o = apply;

  phase_skid_buf #(
    .WIDTH(LANES*PHASE_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .in_vld  (gen),
    .in_rdy  (buf_in_rdy),
    .in_dat  (lane_dat),
    .out_vld (valid_o),
    .out_rdy (ready_i),
    .out_dat (phase_o)
  );

endmodule

// File: tb/tb_phase_gen_par.sv
// Randomised bench for phase_gen_par against a queue-based beat-stream reference model.
module tb_phase_gen_par;

  logic         clk;
  logic         rst_n;
  logic         en_i;
  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic [31:0]  cfg_pinc_i;
  logic [31:0]  cfg_poff_i;
  logic         cfg_sync_i;
  logic         cfg_applied_o;
  logic [127:0] phase_o;
  logic         valid_o;
  logic         ready_i;

  int n_chk;
  int n_fail;

  // reference model: active/shadow config, sample phase, expected output beat queue
  bit           m_run;
  bit           m_pend;
  logic [31:0]  m_acc, m_pinc, m_poff;
  logic [31:0]  s_pinc, s_poff;
  bit           s_sync;
  logic [127:0] mq[$];
  bit           m_gen, m_pop, m_accept, m_apply;

  phase_gen_par #(
    .LANES  (4),
    .PHASE_W(32)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_pinc_i   (cfg_pinc_i),
    .cfg_poff_i   (cfg_poff_i),
    .cfg_sync_i   (cfg_sync_i),
    .cfg_applied_o(cfg_applied_o),
    .phase_o      (phase_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_beat(input logic [31:0] a, input logic [31:0] p,
                                           input logic [31:0] o);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = a + o + p * 32'(k);
    return b;
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_pend = 0;
    m_acc  = '0;
    m_pinc = '0;
    m_poff = '0;
    s_pinc = '0;
    s_poff = '0;
    s_sync = 0;
    mq.delete();
  endtask

  // mid-cycle: predict this cycle's events and compare outputs
  task automatic settle();
    @(negedge clk);
    m_gen    = m_run && ((mq.size() < 2) || ready_i);
    m_pop    = (mq.size() > 0) && ready_i;
    m_accept = cfg_valid_i && !m_pend;
    m_apply  = m_pend && (m_gen || !m_run);
    check("valid", 128'(valid_o), 128'(mq.size() > 0));
    if (mq.size() > 0) check("phase", phase_o, mq[0]);
    check("cfg_ready", 128'(cfg_ready_o), 128'(!m_pend));
    check("cfg_applied", 128'(cfg_applied_o), 128'(m_apply));
  endtask

  task automatic advance();
    logic [31:0] nxt_acc;
    @(posedge clk);
    if (m_pop) void'(mq.pop_front());
    if (m_gen) mq.push_back(mk_beat(m_acc, m_pinc, m_poff));
    nxt_acc = m_gen ? m_acc + m_pinc * 32'd4 : m_acc;
    if (m_apply) begin
      m_pinc = s_pinc;
      m_poff = s_poff;
      if (s_sync) nxt_acc = '0;
      m_pend = 0;
    end else if (m_accept) begin
      s_pinc = cfg_pinc_i;
      s_poff = cfg_poff_i;
      s_sync = cfg_sync_i;
      m_pend = 1;
    end
    m_acc = nxt_acc;
    m_run = en_i;
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic offer(input logic [31:0] p, input logic [31:0] o, input logic s);
    cfg_valid_i = 1'b1;
    cfg_pinc_i  = p;
    cfg_poff_i  = o;
    cfg_sync_i  = s;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    model_reset();
    rst_n = 1'b0;
    en_i = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_pinc_i = '0;
    cfg_poff_i = '0;
    cfg_sync_i = 1'b0;
    ready_i = 1'b1;
    #3;
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_phase", phase_o, 128'(0));
    check("rst_cfg_ready", 128'(cfg_ready_o), 128'(1));
    check("rst_applied", 128'(cfg_applied_o), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: basic sequence and en_i -> valid_o latency
    offer(32'h1000, 32'h0, 1'b1);
    cycle();
    cfg_valid_i = 1'b0;
    settle();
    check("t1_applied_idle", 128'(cfg_applied_o), 128'(1));
    advance();
    en_i = 1'b1;
    cycle();
    settle();
    check("t1_no_valid_n1", 128'(valid_o), 128'(0));
    advance();
    settle();
    check("t1_valid_n2", 128'(valid_o), 128'(1));
    check("t1_beat0", phase_o, 128'h00003000_00002000_00001000_00000000);
    advance();
    settle();
    check("t1_beat1", phase_o, 128'h00007000_00006000_00005000_00004000);
    advance();
    repeat (3) cycle();

    // 3: backpressure hold
    ready_i = 1'b0;
    repeat (5) cycle();
    ready_i = 1'b1;
    repeat (4) cycle();

    // 4: mid-stream reconfig, second offer stalled while pending
    offer(32'h2000, 32'h10, 1'b0);
    cycle();
    offer(32'h3000, 32'h0, 1'b0);
    settle();
    check("t4_stalled", 128'(cfg_ready_o), 128'(0));
    advance();
    repeat (3) cycle();
    cfg_valid_i = 1'b0;
    repeat (4) cycle();

    // 5: en_i low then resume
    en_i = 1'b0;
    repeat (10) cycle();
    en_i = 1'b1;
    repeat (6) cycle();

    // 2: quarter-turn increment wraps every beat
    en_i = 1'b0;
    repeat (4) cycle();
    offer(32'h4000_0000, 32'h0, 1'b1);
    cycle();
    cfg_valid_i = 1'b0;
    cycle();
    en_i = 1'b1;
    cycle();
    cycle();
    settle();
    check("t2_beat0", phase_o, 128'hC0000000_80000000_40000000_00000000);
    advance();
    settle();
    check("t2_beat1", phase_o, 128'hC0000000_80000000_40000000_00000000);
    advance();

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) en_i = ~en_i;
      ready_i = ($urandom_range(3) != 0);
      cfg_valid_i = ($urandom_range(7) == 0);
      cfg_pinc_i = $urandom;
      cfg_poff_i = $urandom;
      cfg_sync_i = 1'($urandom_range(1));
      cycle();
    end

    // 6: asynchronous reset mid-stream
    cfg_valid_i = 1'b0;
    ready_i = 1'b1;
    en_i = 1'b1;
    repeat (4) cycle();
    rst_n = 1'b0;
    #2;
    check("t6_async_valid", 128'(valid_o), 128'(0));
    check("t6_async_phase", phase_o, 128'(0));
    check("t6_async_cfg_ready", 128'(cfg_ready_o), 128'(1));
    model_reset();
    en_i = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    en_i = 1'b1;
    cycle();
    cycle();
    settle();
    check("t6_valid", 128'(valid_o), 128'(1));
    check("t6_zero_phase", phase_o, 128'(0));
    advance();
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
